power_rail_sequencer: RTL and testbench

Parametrised N-rail power sequencer for DSP/FPGA supply trees. It brings rails up in index order and down in reverse order, gating each step on debounced power-good inputs with per-step timeouts. It then releases the target device's POR, RESET and RESETFULL lines and waits for RESETSTAT. Faults are latched with a cause code and rail index for the supervisor. It replaces hand-written fixed-rail sequencers on new boards.

---
 rtl/power_seq_pkg.sv | 29 ++
 rtl/rail_debounce.sv | 38 +++
 rtl/power_rail_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_power_rail_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_seq_pkg.sv
// Shared types and constants for the power rail sequencer.
// State encoding, fault cause codes and a width helper.
package power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_RAMP_UP    = 3'd1,
    ST_RST_HOLD   = 3'd2,
    ST_POR_HOLD   = 3'd3,
    ST_AWAIT_STAT = 3'd4,
    ST_ON         = 3'd5,
    ST_RAMP_DOWN  = 3'd6
  } state_e;

  localparam logic [1:0] FAULT_NONE         = 2'd0;
  localparam logic [1:0] FAULT_RAMP_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_RAIL_DROP    = 2'd2;
  localparam logic [1:0] FAULT_STAT_TIMEOUT = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rail_debounce.sv
// Power-good debouncer for one rail.
// ok only after DEBOUNCE_TICKS consecutive good ticks.
module rail_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic tick,
  input  logic raw,
  output logic ok
);

  localparam logic [3:0] SAT = 4'(DEBOUNCE_TICKS);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // A low sample restarts the count at once, tick or not.
  always_comb begin
    cnt_d = cnt_q;
    if (!raw) begin
      cnt_d = '0;
    end else if (tick && cnt_q != SAT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ok = (cnt_q == SAT);

endmodule

// File: rtl/power_rail_sequencer.sv
// N-rail power sequencer: ordered ramp up/down, target reset release,
// sticky fault capture with cause code and rail index.
module power_rail_sequencer
  import power_seq_pkg::*;
#(
  parameter int N_RAILS          = 4,
  parameter int TICK_DIV         = 500,
  parameter int DEBOUNCE_TICKS   = 4,
  parameter int TIMEOUT_TICKS    = 250,
  parameter int POR_DELAY_TICKS  = 2,
  parameter int FULL_DELAY_TICKS = 1,
  parameter int HOLDOFF_TICKS    = 250
) (
  input  logic                       sysclk,
  input  logic                       reset_INV,
  input  logic                       enable,
  input  logic [N_RAILS-1:0]         rail_good,
  input  logic                       resetstat_INV,
  input  logic                       clear_fault,
  output logic [N_RAILS-1:0]         rail_en,
  output logic                       por_INV,
  output logic                       dev_reset_INV,
  output logic                       resetfull_INV,
  output logic                       powered,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [clog2(N_RAILS)-1:0]  fault_rail
);

  localparam int RW  = clog2(N_RAILS);
  localparam int DW  = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam int TM0 = (TIMEOUT_TICKS > POR_DELAY_TICKS) ?
                       TIMEOUT_TICKS : POR_DELAY_TICKS;
  localparam int TMAX = (TM0 > FULL_DELAY_TICKS) ? TM0 : FULL_DELAY_TICKS;
  localparam int TW  = (clog2(TMAX + 1) > 0) ? clog2(TMAX + 1) : 1;
  localparam int HW  = (clog2(HOLDOFF_TICKS + 1) > 0) ?
                       clog2(HOLDOFF_TICKS + 1) : 1;

  state_e          state_q, state_d;
  logic [RW-1:0]   k_q, k_d;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;
  logic [RW-1:0]   frail_q, frail_d;

  logic            tick;
  logic            timeout;
  logic [N_RAILS-1:0] ok;
  logic            drop_any, below_any;
  logic [RW-1:0]   drop_idx, below_idx;
  logic            flt_now;
  logic [1:0]      flt_code;
  logic [RW-1:0]   flt_rail;
  logic            active;

  assign tick    = (div_q == DW'(TICK_DIV - 1));
  assign div_d   = tick ? '0 : div_q + DW'(1);
  assign timeout = (timer_q >= TW'(TIMEOUT_TICKS));

  for (genvar g = 0; g < N_RAILS; g++) begin : g_deb
    rail_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .sysclk   (sysclk),
      .reset_INV(reset_INV),
      .tick     (tick),
      .raw      (rail_good[g]),
      .ok       (ok[g])
    );
  end

  // Scan downwards so the last hit is the lowest failing rail.
  always_comb begin
    drop_any  = 1'b0;
    drop_idx  = '0;
    below_any = 1'b0;
    below_idx = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (!ok[i]) begin
        drop_any = 1'b1;
        drop_idx = RW'(i);
        if (RW'(i) < k_q) begin
          below_any = 1'b1;
          below_idx = RW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    hold_d   = hold_q;
    flt_now  = 1'b0;
    flt_code = FAULT_NONE;
    flt_rail = '0;
    active   = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (enable && !fault_q && hold_q == '0) begin
          state_d = ST_RAMP_UP;
          k_d     = '0;
        end else if (tick && hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_RAMP_UP: begin
        active = 1'b1;
        if (below_any) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAIL_DROP;
          flt_rail = below_idx;
        end else if (ok[k_q]) begin
          if (k_q == RW'(N_RAILS - 1)) begin
            state_d = ST_RST_HOLD;
          end else begin
            k_d = k_q + RW'(1);
          end
        end else if (timeout) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAMP_TIMEOUT;
          flt_rail = k_q;
        end
      end
      ST_RST_HOLD: begin
        active = 1'b1;
        if (drop_any) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAIL_DROP;
          flt_rail = drop_idx;
        end else if (timer_q >= TW'(POR_DELAY_TICKS)) begin
          state_d = ST_POR_HOLD;
        end
      end
      ST_POR_HOLD: begin
        active = 1'b1;
        if (drop_any) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAIL_DROP;
          flt_rail = drop_idx;
        end else if (timer_q >= TW'(FULL_DELAY_TICKS)) begin
          state_d = ST_AWAIT_STAT;
        end
      end
      ST_AWAIT_STAT: begin
        active = 1'b1;
        if (drop_any) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAIL_DROP;
          flt_rail = drop_idx;
        end else if (!resetstat_INV) begin
          state_d = ST_ON;
        end else if (timeout) begin
          flt_now  = 1'b1;
          flt_code = FAULT_STAT_TIMEOUT;
          flt_rail = '0;
        end
      end
      ST_ON: begin
        active = 1'b1;
        if (drop_any) begin
          flt_now  = 1'b1;
          flt_code = FAULT_RAIL_DROP;
          flt_rail = drop_idx;
        end
      end
      ST_RAMP_DOWN: begin
        if (!rail_good[k_q] || timeout) begin
          if (k_q == '0) begin
            state_d = ST_OFF;
            hold_d  = HW'(HOLDOFF_TICKS);
          end else begin
            k_d = k_q - RW'(1);
          end
        end
      end
      default: begin
        state_d = ST_OFF;
        k_d     = '0;
      end
    endcase
    // Shutdown starts from the highest rail that is currently on.
    if (active && (!enable || flt_now)) begin
      state_d = ST_RAMP_DOWN;
      k_d     = (state_q == ST_RAMP_UP) ? k_q : RW'(N_RAILS - 1);
    end
  end

  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    frail_d = frail_q;
    if (flt_now) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        code_d  = flt_code;
        frail_d = flt_rail;
      end
    end else if (clear_fault) begin
      fault_d = 1'b0;
      code_d  = FAULT_NONE;
      frail_d = '0;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || k_d != k_q) begin
      timer_d = '0;
    end else if (tick && timer_q != TW'(TMAX)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      state_q <= ST_OFF;
      k_q     <= '0;
      div_q   <= '0;
      timer_q <= '0;
      hold_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= FAULT_NONE;
      frail_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      frail_q <= frail_d;
    end
  end

  always_comb begin
    rail_en       = '0;
    dev_reset_INV = 1'b0;
    por_INV       = 1'b0;
    resetfull_INV = 1'b0;
    powered       = 1'b0;
    unique case (state_q)
      ST_RAMP_UP: begin
        for (int i = 0; i < N_RAILS; i++) begin
          rail_en[i] = (RW'(i) <= k_q);
        end
      end
      ST_RST_HOLD: begin
        rail_en       = '1;
        dev_reset_INV = 1'b1;
      end
      ST_POR_HOLD: begin
        rail_en       = '1;
        dev_reset_INV = 1'b1;
        por_INV       = 1'b1;
      end
      ST_AWAIT_STAT: begin
        rail_en       = '1;
        dev_reset_INV = 1'b1;
        por_INV       = 1'b1;
        resetfull_INV = 1'b1;
      end
      ST_ON: begin
        rail_en       = '1;
        dev_reset_INV = 1'b1;
        por_INV       = 1'b1;
        resetfull_INV = 1'b1;
        powered       = 1'b1;
      end
      ST_RAMP_DOWN: begin
        for (int i = 0; i < N_RAILS; i++) begin
          rail_en[i] = (RW'(i) < k_q);
        end
      end
      default: begin
        rail_en = '0;
      end
    endcase
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_rail = frail_q;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Scoreboard bench: expected output snapshots with cycle windows are
// queued by the stimulus and popped by a monitor on each output change.
module tb_power_rail_sequencer;

  localparam int ANY = 100000;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       enable;
  logic [3:0] rail_good;
  logic       resetstat_INV;
  logic       clear_fault;
  logic [3:0] rail_en;
  logic       por_INV, dev_reset_INV, resetfull_INV, powered, fault;
  logic [1:0] fault_code, fault_rail;

  logic [3:0] ovr_en, ovr_val;
  logic [3:0] dl [4];
  logic [1:0] sd;
  logic       mon_en, mon_first;
  int         n_cmp = 0, n_bad = 0, cyc = 0, step = 0;

  typedef struct {
    logic [12:0] v;
    int          lo;
    int          hi;
  } exp_t;
  exp_t q[$];

  always #5 sysclk = ~sysclk;

  power_rail_sequencer #(
    .N_RAILS         (4),
    .TICK_DIV        (4),
    .DEBOUNCE_TICKS  (2),
    .TIMEOUT_TICKS   (8),
    .POR_DELAY_TICKS (2),
    .FULL_DELAY_TICKS(1),
    .HOLDOFF_TICKS   (6)
  ) dut (
    .sysclk       (sysclk),
    .reset_INV    (reset_INV),
    .enable       (enable),
    .rail_good    (rail_good),
    .resetstat_INV(resetstat_INV),
    .clear_fault  (clear_fault),
    .rail_en      (rail_en),
    .por_INV      (por_INV),
    .dev_reset_INV(dev_reset_INV),
    .resetfull_INV(resetfull_INV),
    .powered      (powered),
    .fault        (fault),
    .fault_code   (fault_code),
    .fault_rail   (fault_rail)
  );

  // Board model: each rail follows its enable four cycles later.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rail_good[i] = ovr_en[i] ? ovr_val[i] : dl[i][3];
    end
  end
  assign resetstat_INV = ~sd[1];

  initial begin
    for (int i = 0; i < 4; i++) dl[i] = 4'b0000;
    sd = 2'b00;
    forever begin
      @(negedge sysclk);
      for (int i = 0; i < 4; i++) dl[i] = {dl[i][2:0], rail_en[i]};
      sd = {sd[0], resetfull_INV};
    end
  end

  function automatic logic [12:0] snap();
    return {rail_en, dev_reset_INV, por_INV, resetfull_INV, powered,
            fault, fault_code, fault_rail};
  endfunction

  function automatic logic [12:0] mk(input logic [3:0] en,
                                     input logic [3:0] ctl,
                                     input logic [4:0] flt);
    return {en, ctl, flt};
  endfunction

  task automatic push(input logic [12:0] v, input int lo, input int hi);
    exp_t e;
    e.v  = v;
    e.lo = lo;
    e.hi = hi;
    q.push_back(e);
  endtask

  task automatic push_up_tail();
    push(mk(4'b0111, 4'b0000, 5'b0), 9, 12);
    push(mk(4'b1111, 4'b0000, 5'b0), 9, 12);
    push(mk(4'b1111, 4'b1000, 5'b0), 9, 12);
    push(mk(4'b1111, 4'b1100, 5'b0), 6, 9);
    push(mk(4'b1111, 4'b1110, 5'b0), 2, 5);
    push(mk(4'b1111, 4'b1111, 5'b0), 2, 2);
  endtask

  task automatic push_up_rest();
    push(mk(4'b0011, 4'b0000, 5'b0), 9, 12);
    push_up_tail();
  endtask

  task automatic push_down(input logic [4:0] flt);
    push(mk(4'b0111, 4'b0000, flt), 0, ANY);
    push(mk(4'b0011, 4'b0000, flt), 4, 4);
    push(mk(4'b0001, 4'b0000, flt), 4, 4);
    push(mk(4'b0000, 4'b0000, flt), 4, 4);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_en(input logic [3:0] val, input int budget);
    int n;
    n = 0;
    while (rail_en !== val && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    if (rail_en !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_en: got %b, required %b", rail_en, val);
    end
  endtask

  initial begin
    logic [12:0] s, prev;
    exp_t        e;
    int          last, dt;
    prev = '0;
    last = 0;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (mon_en && (mon_first || snap() !== prev)) begin
        s  = snap();
        dt = cyc - last;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected: got %b, required no change", s);
        end else begin
          e = q.pop_front();
          if (s !== e.v || (!mon_first && (dt < e.lo || dt > e.hi))) begin
            n_bad++;
            $display("FAIL step%0d: got %b dt %0d, required %b dt %0d..%0d",
                     step, s, dt, e.v, e.lo, e.hi);
          end
        end
        step++;
        prev      = s;
        last      = cyc;
        mon_first = 1'b0;
      end
    end
  end

  initial begin
    reset_INV   = 1'b0;
    enable      = 1'b0;
    clear_fault = 1'b0;
    ovr_en      = 4'b0000;
    ovr_val     = 4'b0000;
    mon_en      = 1'b0;
    mon_first   = 1'b0;
    repeat (3) @(negedge sysclk);
    reset_INV = 1'b1;
    push(13'b0, 0, ANY);
    mon_en    = 1'b1;
    mon_first = 1'b1;
    repeat (2) @(negedge sysclk);

    // Nominal power-up from reset, no holdoff delay.
    push(mk(4'b0001, 4'b0000, 5'b0), 0, ANY);
    push_up_rest();
    enable = 1'b1;
    drain(400);

    // One-cycle drop of rail 1 while ON.
    push_down(5'b1_10_01);
    ovr_en[1]  = 1'b1;
    ovr_val[1] = 1'b0;
    @(negedge sysclk);
    ovr_en[1] = 1'b0;
    drain(100);

    // Sticky fault blocks restart until cleared.
    repeat (40) @(negedge sysclk);
    push(13'b0, 0, ANY);
    push(mk(4'b0001, 4'b0000, 5'b0), 1, 1);
    push_up_rest();
    clear_fault = 1'b1;
    @(negedge sysclk);
    clear_fault = 1'b0;
    drain(400);

    // Enable bounce while ON: full ramp-down, then holdoff.
    push_down(5'b0);
    push(mk(4'b0001, 4'b0000, 5'b0), 26, 29);
    push_up_rest();
    enable = 1'b0;
    @(negedge sysclk);
    enable = 1'b1;
    drain(600);

    // Ramp timeout on rail 2.
    push_down(5'b0);
    enable = 1'b0;
    drain(100);
    ovr_en[2]  = 1'b1;
    ovr_val[2] = 1'b0;
    repeat (40) @(negedge sysclk);
    push(mk(4'b0001, 4'b0000, 5'b0), 0, ANY);
    push(mk(4'b0011, 4'b0000, 5'b0), 9, 12);
    push(mk(4'b0111, 4'b0000, 5'b0), 9, 12);
    push(mk(4'b0011, 4'b0000, 5'b1_01_10), 30, 33);
    push(mk(4'b0001, 4'b0000, 5'b1_01_10), 1, 1);
    push(mk(4'b0000, 4'b0000, 5'b1_01_10), 4, 4);
    enable = 1'b1;
    drain(400);

    // Clear, ramp to rail 2, then reset mid-ramp.
    repeat (40) @(negedge sysclk);
    ovr_en[2] = 1'b0;
    push(13'b0, 0, ANY);
    push(mk(4'b0001, 4'b0000, 5'b0), 1, 1);
    push(mk(4'b0011, 4'b0000, 5'b0), 9, 12);
    push(mk(4'b0111, 4'b0000, 5'b0), 9, 12);
    clear_fault = 1'b1;
    @(negedge sysclk);
    clear_fault = 1'b0;
    drain(200);
    push(13'b0, 1, 1);
    push(mk(4'b0001, 4'b0000, 5'b0), 2, 2);
    push(mk(4'b0011, 4'b0000, 5'b0), 18, 21);
    push_up_tail();
    ovr_en[0]  = 1'b1;
    ovr_val[0] = 1'b0;
    reset_INV  = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    reset_INV = 1'b1;

    // Single-tick glitch on rail 0 must not advance.
    wait_en(4'b0001, 20);
    repeat (4) @(negedge sysclk);
    ovr_val[0] = 1'b1;
    repeat (4) @(negedge sysclk);
    ovr_val[0] = 1'b0;
    repeat (4) @(negedge sysclk);
    ovr_en[0] = 1'b0;
    drain(400);

    push_down(5'b0);
    enable = 1'b0;
    drain(100);
    repeat (10) @(negedge sysclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
